// File: rtl/gen_write_logic_mdio.sv
// MDIO-side write path into the capture memories: one 9-bit lane is written
// per request through a read / merge / write-back sequence on the shared port.
module gen_write_logic_mdio #(
    parameter int NUM_MEM = 24,
    parameter int DW      = 36,
    parameter int LW      = 9,
    parameter int AW      = 15,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [6:0]            rf_mdio_data_sel,
    input  logic [AW-1:0]         rf_mdio_memory_addr,
    input  logic [LW-1:0]         rf_mdio_wdata,
    input  logic                  mdio_write_req,
    input  logic                  mdio_read_en,
    input  logic [NUM_MEM*DW-1:0] mdio_din,
    output logic [NUM_MEM-1:0]    mdio_chip_en,
    output logic                  mdio_wr_en,
    output logic [AW-1:0]         mdio_addr,
    output logic [DW-1:0]         mdio_dout,
    output logic                  mdio_write_busy,
    output logic                  mdio_write_done,
    output logic                  mdio_write_err
);

    localparam int         NUM_LANES = DW / LW;
    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);
    localparam logic [6:0] SEL_MAX   = 7'(NUM_MEM * NUM_LANES - 1);

    typedef enum logic [2:0] {IDLE, HOLD, RD, WAIT, WR, DONE} state_t;

    state_t               state_q, state_d;
    logic [6:0]           sel_q, sel_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [LW-1:0]        wdata_q, wdata_d;
    logic [DW-1:0]        merge_q, merge_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [NUM_MEM-1:0]   chip_en_q, chip_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        maddr_q, maddr_d;
    logic [DW-1:0]        dout_q, dout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [DW-1:0]        din_words [NUM_MEM];
    logic [NUM_MEM-1:0]   sel_onehot;
    logic [DW-1:0]        rd_word;
    logic [DW-1:0]        merged;
    logic                 access;

    // Split the flat read bus per memory; one-hot enable follows the next select
    // so the registered chip enable lines up with the RD/WR cycle.
    for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_mem
        assign din_words[gi]  = mdio_din[gi*DW +: DW];
        assign sel_onehot[gi] = (sel_d[6:2] == 5'(gi));
    end

    always_comb begin
        rd_word = din_words[sel_q[6:2]];
        merged  = rd_word;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (sel_q[1:0] == 2'(l)) begin
                merged[l*LW +: LW] = wdata_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdio_write_req) begin
                    sel_d   = rf_mdio_data_sel;
                    addr_d  = rf_mdio_memory_addr;
                    wdata_d = rf_mdio_wdata;
                    if (rf_mdio_data_sel > SEL_MAX) begin
                        err_d = 1'b1;
                    end else if (mdio_read_en) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            HOLD: begin
                if (!mdio_read_en) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = WAIT;
                cnt_d   = WAIT_INIT;
            end
            WAIT: begin
                // Read data is valid on the last WAIT edge only.
                if (cnt_q == 3'd0) begin
                    merge_d = merged;
                    state_d = WR;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        access    = (state_d == RD) || (state_d == WR);
        chip_en_d = access ? sel_onehot : '0;
        wr_en_d   = (state_d == WR);
        maddr_d   = access ? addr_d : '0;
        dout_d    = (state_d == WR) ? merge_d : '0;
        busy_d    = (state_d == HOLD) || (state_d == RD) || (state_d == WAIT) || (state_d == WR);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            merge_q   <= '0;
            cnt_q     <= '0;
            chip_en_q <= '0;
            wr_en_q   <= 1'b0;
            maddr_q   <= '0;
            dout_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            merge_q   <= merge_d;
            cnt_q     <= cnt_d;
            chip_en_q <= chip_en_d;
            wr_en_q   <= wr_en_d;
            maddr_q   <= maddr_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign mdio_chip_en    = chip_en_q;
    assign mdio_wr_en      = wr_en_q;
    assign mdio_addr       = maddr_q;
    assign mdio_dout       = dout_q;
    assign mdio_write_busy = busy_q;
    assign mdio_write_done = done_q;
    assign mdio_write_err  = err_q;

endmodule

// File: tb/tb_gen_write_logic_mdio.sv
// Scoreboard bench for gen_write_logic_mdio: two instances (read latency 1 and 3)
// run against a behavioural memory model that drives garbage outside valid read slots.
module tb_gen_write_logic_mdio;

    localparam int NM = 24;
    localparam int DW = 36;
    localparam int LW = 9;
    localparam int AW = 15;
    localparam logic [DW-1:0] GARB = 36'hBAD_BAD_BAD;

    typedef struct {
        logic [NM-1:0] chip;
        logic [AW-1:0] addr;
        logic [DW-1:0] dout;
        int            req_cyc;
        int            lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [6:0]       sel = '0;
    logic [AW-1:0]    addr = '0;
    logic [LW-1:0]    wd = '0;
    logic             req [2];
    logic             rd_en = 1'b0;
    logic [NM*DW-1:0] din [2];
    logic [NM-1:0]    chip_en [2];
    logic             wr_en [2];
    logic [AW-1:0]    maddr [2];
    logic [DW-1:0]    dout [2];
    logic             busy [2];
    logic             done [2];
    logic             err [2];

    exp_t             q [2][$];
    exp_t             cur [2];
    bit               cur_v [2];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;

    logic [DW-1:0]    mem [2][NM][16];
    logic             sv [2][3];
    int               sk [2][3];
    logic [DW-1:0]    sd [2][3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gen_write_logic_mdio #(.RD_LAT(1)) dut_l1 (
        .clk(clk), .rstn(rstn), .rf_mdio_data_sel(sel), .rf_mdio_memory_addr(addr),
        .rf_mdio_wdata(wd), .mdio_write_req(req[0]), .mdio_read_en(rd_en), .mdio_din(din[0]),
        .mdio_chip_en(chip_en[0]), .mdio_wr_en(wr_en[0]), .mdio_addr(maddr[0]), .mdio_dout(dout[0]),
        .mdio_write_busy(busy[0]), .mdio_write_done(done[0]), .mdio_write_err(err[0])
    );

    gen_write_logic_mdio #(.RD_LAT(3)) dut_l3 (
        .clk(clk), .rstn(rstn), .rf_mdio_data_sel(sel), .rf_mdio_memory_addr(addr),
        .rf_mdio_wdata(wd), .mdio_write_req(req[1]), .mdio_read_en(rd_en), .mdio_din(din[1]),
        .mdio_chip_en(chip_en[1]), .mdio_wr_en(wr_en[1]), .mdio_addr(maddr[1]), .mdio_dout(dout[1]),
        .mdio_write_busy(busy[1]), .mdio_write_done(done[1]), .mdio_write_err(err[1])
    );

    function automatic int oh_idx(input logic [NM-1:0] v);
        for (int k = 0; k < NM; k++) if (v[k]) return k;
        return 0;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: registered read with per-instance latency (1 or 3 edges).
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                for (int m = 0; m < NM; m++)
                    for (int a = 0; a < 16; a++) mem[i][m][a] <= '0;
                mem[i][5][4] <= 36'h1_2345_6789;
                for (int s = 0; s < 3; s++) begin
                    sv[i][s] <= 1'b0;
                    sk[i][s] <= 0;
                    sd[i][s] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                sv[i][0] <= (chip_en[i] != '0) && !wr_en[i];
                sk[i][0] <= oh_idx(chip_en[i]);
                sd[i][0] <= mem[i][oh_idx(chip_en[i])][maddr[i][3:0]];
                for (int s = 1; s < 3; s++) begin
                    sv[i][s] <= sv[i][s-1];
                    sk[i][s] <= sk[i][s-1];
                    sd[i][s] <= sd[i][s-1];
                end
                if (wr_en[i]) mem[i][oh_idx(chip_en[i])][maddr[i][3:0]] <= dout[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            din[i] = {NM{GARB}};
            if (sv[i][i*2]) din[i][sk[i][i*2]*DW +: DW] = sd[i][i*2];
        end
    end

    // Monitor: RD/WR cycles popped against the scoreboard, done latency checked.
    always @(negedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                q[i].delete();
                cur_v[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                string p;
                p = (i == 0) ? "l1" : "l3";
                if (wr_en[i]) begin
                    if (q[i].size() == 0) check_val({p, "_unexp_wr"}, 64'(1), 64'(0));
                    else begin
                        cur[i] = q[i].pop_front();
                        cur_v[i] = 1'b1;
                        check_val({p, "_wr_chip"}, 64'(chip_en[i]), 64'(cur[i].chip));
                        check_val({p, "_wr_addr"}, 64'(maddr[i]), 64'(cur[i].addr));
                        check_val({p, "_wr_dout"}, 64'(dout[i]), 64'(cur[i].dout));
                        $display("%s write: chip=%06h addr=%04h dout=%09h", p, chip_en[i], maddr[i], dout[i]);
                    end
                end else if (chip_en[i] != '0) begin
                    if (q[i].size() == 0) check_val({p, "_unexp_chip"}, 64'(chip_en[i]), 64'(0));
                    else begin
                        check_val({p, "_rd_chip"}, 64'(chip_en[i]), 64'(q[i][0].chip));
                        check_val({p, "_rd_addr"}, 64'(maddr[i]), 64'(q[i][0].addr));
                    end
                end
                if (done[i]) begin
                    if (!cur_v[i]) check_val({p, "_unexp_done"}, 64'(1), 64'(0));
                    else begin
                        if (cur[i].lat >= 0)
                            check_val({p, "_latency"}, 64'(cyc - cur[i].req_cyc), 64'(cur[i].lat));
                        check_val({p, "_done_busy"}, 64'(busy[i]), 64'(0));
                        cur_v[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input bit on0, input bit on1, input logic [6:0] s, input logic [AW-1:0] a,
                         input logic [LW-1:0] w, input int lat0, input int lat1);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if ((i == 0) ? on0 : on1) begin
                e.chip = NM'(1) << s[6:2];
                e.addr = a;
                e.dout = mem[i][s[6:2]][a[3:0]];
                e.dout[s[1:0]*LW +: LW] = w;
                e.req_cyc = cyc + 1;
                e.lat = (i == 0) ? lat0 : lat1;
                q[i].push_back(e);
            end
        end
        sel = s; addr = a; wd = w;
        req[0] = on0; req[1] = on1;
        @(negedge clk);
        req[0] = 1'b0; req[1] = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (q[0].size() == 0 && q[1].size() == 0 && !cur_v[0] && !cur_v[1] &&
                !busy[0] && !busy[1] && !done[0] && !done[1]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s_chip%0d", tag, i), 64'(chip_en[i]), 64'(0));
            check_val($sformatf("%s_flags%0d", tag, i), 64'({wr_en[i], busy[i], done[i], err[i]}), 64'(0));
            check_val($sformatf("%s_addr%0d", tag, i), 64'(maddr[i]), 64'(0));
            check_val($sformatf("%s_dout%0d", tag, i), 64'(dout[i]), 64'(0));
        end
    endtask

    initial begin
        req[0] = 1'b0; req[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Basic write: mem 5 lane 2 at 0x1234.
        issue(1, 1, 7'd22, 15'h1234, 9'h1AB, 3, 5);
        wait_quiet("basic");
        check_val("basic_word_l1", 64'(mem[0][5][4]), 64'(36'h1_26AD_6789));
        check_val("basic_word_l3", 64'(mem[1][5][4]), 64'(36'h1_26AD_6789));

        // Lane edges: lowest and highest select.
        issue(1, 1, 7'd0, 15'h0000, 9'h1FF, 3, 5);
        wait_quiet("lane0");
        check_val("lane0_word", 64'(mem[0][0][0]), 64'(36'h0_0000_01FF));
        issue(1, 1, 7'd95, 15'h7FFF, 9'h1FF, 3, 5);
        wait_quiet("lane95");
        check_val("lane95_word_l1", 64'(mem[0][23][15]), 64'(36'hF_F800_0000));
        check_val("lane95_word_l3", 64'(mem[1][23][15]), 64'(36'hF_F800_0000));

        // Invalid select.
        sel = 7'd96; addr = 15'h0011; wd = 9'h0AA;
        req[0] = 1'b1; req[1] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0; req[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("inv_err%0d", i), 64'(err[i]), 64'(1));
            check_val($sformatf("inv_busy%0d", i), 64'({busy[i], wr_en[i], chip_en[i]}), 64'(0));
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_val($sformatf("inv_err_end%0d", i), 64'(err[i]), 64'(0));
        wait_quiet("invalid");
        $display("invalid select 96: err pulse checked");

        // Captured fields frozen; second request and read_en during WAIT ignored.
        issue(1, 0, 7'd10, 15'h0042, 9'h055, 3, -1);
        sel = 7'd50; wd = 9'h0AA; addr = 15'h0045;
        @(negedge clk);
        req[0] = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        req[0] = 1'b0; rd_en = 1'b0;
        wait_quiet("ignore");
        check_val("ignore_word", 64'(mem[0][2][2]), 64'(36'h0_0154_0000));
        check_val("ignore_other", 64'(mem[0][12][5]), 64'(0));

        // Deferral while the read path is active.
        rd_en = 1'b1;
        issue(1, 0, 7'd41, 15'h7FF3, 9'h0F0, -1, -1);
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("hold_busy%0d", k), 64'(busy[0]), 64'(1));
            check_val($sformatf("hold_chip%0d", k), 64'(chip_en[0]), 64'(0));
            @(negedge clk);
        end
        rd_en = 1'b0;
        wait_quiet("hold");
        check_val("hold_word", 64'(mem[0][10][3]), 64'(36'h0_0001_E000));

        // Random lane writes on both latencies.
        for (int r = 0; r < 6; r++) begin
            issue(1, 1, 7'($urandom_range(0, 95)), 15'($urandom), 9'($urandom), 3, 5);
            wait_quiet("rand");
        end

        // Reset during WAIT, then a fresh request.
        issue(1, 1, 7'd77, 15'h0101, 9'h123, 3, 5);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        issue(1, 1, 7'd77, 15'h0101, 9'h123, 3, 5);
        wait_quiet("postrst");
        check_val("postrst_word_l1", 64'(mem[0][19][1]), 64'(36'h0_0002_4600));
        check_val("postrst_word_l3", 64'(mem[1][19][1]), 64'(36'h0_0002_4600));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
